e_mdu: RTL



---
 rtl/e_mdu_if.sv | 14 +
 rtl/e_mdu.sv | 115 +++++++++++
 2 files changed

// File: rtl/e_mdu_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// Signal names follow the pipeline's existing port names.
interface e_mdu_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// The result is computed at issue, held in PHI/PLO and committed when the count expires.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic    Clk,
    input logic    Rst,
    e_mdu_if.slave mdu
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     phi_q, phi_d, plo_q, plo_d;
    logic            commit_q, commit_d;

    logic        is_signed;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Signed division via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
    always_comb begin
        is_signed = (mdu.MDOp == 3'd1) || (mdu.MDOp == 3'd3);
        if (is_signed) begin
            prod = {{32{mdu.A[31]}}, mdu.A} * {{32{mdu.B[31]}}, mdu.B};
        end else begin
            prod = {32'd0, mdu.A} * {32'd0, mdu.B};
        end
        a_mag = (is_signed && mdu.A[31]) ? (~mdu.A + 32'd1) : mdu.A;
        b_mag = (is_signed && mdu.B[31]) ? (~mdu.B + 32'd1) : mdu.B;
        q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        quo   = (is_signed && (mdu.A[31] ^ mdu.B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (is_signed && mdu.A[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        commit_d = commit_q;
        unique case (state_q)
            StIdle: begin
                if (mdu.Start) begin
                    case (mdu.MDOp)
                        3'd1, 3'd2: begin
                            phi_d    = prod[63:32];
                            plo_d    = prod[31:0];
                            commit_d = 1'b1;
                            cnt_d    = CntW'(MULT_CYCLES);
                            state_d  = StRun;
                        end
                        3'd3, 3'd4: begin
                            phi_d    = rem;
                            plo_d    = quo;
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            commit_d = (mdu.B != 32'd0);
                            cnt_d    = CntW'(DIV_CYCLES);
                            state_d  = StRun;
                        end
                        3'd5:    hi_d = mdu.A;
                        3'd6:    lo_d = mdu.A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (commit_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            commit_q <= commit_d;
        end
    end

    assign mdu.Busy = (state_q == StRun);
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;
endmodule
